// File: rtl/risc_pkg.sv
// Shared encodings for the RISC fetch stage: branch-select codes, NOP word, taken-redirect decode.
// Latency: none; declarations and a purely combinational helper.
// Backpressure: not applicable.
package risc_pkg;

  // Branch-select codes as driven by the EX/WB stage
  localparam logic [1:0] BS_SEQ  = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JR   = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

  // All-zero word is the pipeline NOP; bubbles carry this in IR
  localparam int unsigned NOP_INSTR = 0;

  // Which redirect, if any, is taken this cycle
  typedef enum logic [1:0] {
    TAKEN_NONE = 2'b00,
    TAKEN_COND = 2'b01,
    TAKEN_JR   = 2'b10,
    TAKEN_JMP  = 2'b11
  } taken_sel_t;

  // A conditional branch is taken when the polarity select disagrees with Z
  function automatic taken_sel_t decode_taken(
    input logic [1:0] bs,
    input logic       ps,
    input logic       z
  );
    taken_sel_t sel;
    sel = TAKEN_NONE;
    case (bs)
      BS_COND: sel = (ps ^ z) ? TAKEN_COND : TAKEN_NONE;
      BS_JR:   sel = TAKEN_JR;
      BS_JMP:  sel = TAKEN_JMP;
      default: sel = TAKEN_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/risc_imem.sv
// Writable instruction memory: asynchronous read port, synchronous write port.
// Latency: read is combinational; a write lands at the rising edge, so a same-edge read sees the old word.
// Backpressure: none; a write is accepted in every cycle, reset included.
module risc_imem
  import risc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Contents power up as zero (memory init) and are never cleared by reset,
  // so a program loaded under reset survives the release.
  logic [DATA_W-1:0] mem [DEPTH];

  // Asynchronous read; the IF/DOF register captures it at the edge.
  assign rdata = mem[raddr];

  // Synchronous write; the old word stays visible to a same-cycle fetch.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/risc_if_stage.sv
// Instruction fetch: PC register, instruction memory and IF/DOF pipeline register.
// Latency: 1 cycle PC to IF_DOF_*; a taken redirect inserts one bubble before the target.
// Backpressure: stall holds PC and IF/DOF; a redirect overrides stall.
module risc_if_stage
  import risc_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              EX_WB_Z,
  input  logic              EX_WB_PS,
  input  logic [1:0]        EX_WB_BS,
  input  logic [DATA_W-1:0] EX_WB_BrA,
  input  logic [DATA_W-1:0] EX_WB_RAA,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic [DATA_W-1:0] IF_DOF_PC,
  output logic [DATA_W-1:0] IF_DOF_NPC,
  output logic [DATA_W-1:0] IF_DOF_IR,
  output logic              IF_DOF_VALID,
  output logic [CNT_W-1:0]  redirect_cnt
);

  // Contents of the IF/DOF pipeline register
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] ir;
    logic              valid;
  } ifdof_t;

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;
  logic [DATA_W-1:0] pc_plus1;
  ifdof_t            ifdof_q;
  ifdof_t            ifdof_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  taken_sel_t        taken_sel;
  logic              redirect;
  logic [DATA_W-1:0] target;

  logic [ADDR_W-1:0] fetch_idx;
  logic [DATA_W-1:0] fetch_word;

  // Only the low bits index memory; the full PC is kept so targets beyond
  // the memory depth stay visible downstream while fetch wraps.
  assign fetch_idx = pc_q[ADDR_W-1:0];
  assign pc_plus1  = pc_q + DATA_W'(1);

  risc_imem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk   (clk),
    .raddr (fetch_idx),
    .rdata (fetch_word),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata)
  );

  // Redirect decode from the resolving EX/WB instruction
  always_comb begin
    taken_sel = decode_taken(EX_WB_BS, EX_WB_PS, EX_WB_Z);
    redirect  = (taken_sel != TAKEN_NONE);
    target    = (taken_sel == TAKEN_JR) ? EX_WB_RAA : EX_WB_BrA;
  end

  // Next-state selection: redirect beats stall, stall beats sequential fetch
  always_comb begin
    pc_d    = pc_q;
    ifdof_d = ifdof_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      // Wrong-path slot becomes a bubble; PC/NPC are left as they were.
      pc_d          = target;
      ifdof_d.ir    = DATA_W'(NOP_INSTR);
      ifdof_d.valid = 1'b0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!stall) begin
      pc_d          = pc_plus1;
      ifdof_d.pc    = pc_q;
      ifdof_d.npc   = pc_plus1;
      ifdof_d.ir    = fetch_word;
      ifdof_d.valid = 1'b1;
    end
  end

  // State registers with synchronous reset; memory is outside this reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifdof_q.pc    <= '0;
      ifdof_q.npc   <= '0;
      ifdof_q.ir    <= DATA_W'(NOP_INSTR);
      ifdof_q.valid <= 1'b0;
      cnt_q         <= '0;
    end else begin
      pc_q    <= pc_d;
      ifdof_q <= ifdof_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IF_DOF_PC    = ifdof_q.pc;
  assign IF_DOF_NPC   = ifdof_q.npc;
  assign IF_DOF_IR    = ifdof_q.ir;
  assign IF_DOF_VALID = ifdof_q.valid;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_risc_if_stage.sv
// Scoreboard bench for risc_if_stage against a behavioural fetch model.
// Latency: expectations are pushed at the driving negedge, checked 2 time units after the next posedge.
// Backpressure: stall and redirect are exercised directly and randomly.
module tb_risc_if_stage;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 8;
  localparam int          CNT_W    = 3;
  localparam int          DEPTH    = 256;
  localparam int          CNT_MAX  = 7;
  localparam logic [31:0] RESET_PC = 32'h0000_01FE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        EX_WB_Z = 1'b0;
  logic        EX_WB_PS = 1'b0;
  logic [1:0]  EX_WB_BS = 2'b00;
  logic [31:0] EX_WB_BrA = '0;
  logic [31:0] EX_WB_RAA = '0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] IF_DOF_PC;
  logic [31:0] IF_DOF_NPC;
  logic [31:0] IF_DOF_IR;
  logic        IF_DOF_VALID;
  logic [2:0]  redirect_cnt;

  risc_if_stage #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .EX_WB_Z      (EX_WB_Z),
    .EX_WB_PS     (EX_WB_PS),
    .EX_WB_BS     (EX_WB_BS),
    .EX_WB_BrA    (EX_WB_BrA),
    .EX_WB_RAA    (EX_WB_RAA),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .IF_DOF_PC    (IF_DOF_PC),
    .IF_DOF_NPC   (IF_DOF_NPC),
    .IF_DOF_IR    (IF_DOF_IR),
    .IF_DOF_VALID (IF_DOF_VALID),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
    logic        valid;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;

  // Behavioural model: the program counter, a plain memory array and the
  // last visible IF/DOF contents.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc;
  exp_t        m_out;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_pc = RESET_PC;
    m_out.pc = '0; m_out.npc = '0; m_out.ir = '0; m_out.valid = 1'b0; m_out.cnt = 0;
  end

  // One clock of stimulus: drive at negedge, predict the next edge, queue it
  task automatic cyc(input logic rst, input logic stl, input logic [1:0] bs,
                     input logic ps, input logic z, input logic [31:0] bra,
                     input logic [31:0] raa, input logic we, input logic [7:0] wa,
                     input logic [31:0] wd);
    bit          taken;
    logic [31:0] tgt;
    @(negedge clk);
    reset = rst; stall = stl; EX_WB_BS = bs; EX_WB_PS = ps; EX_WB_Z = z;
    EX_WB_BrA = bra; EX_WB_RAA = raa;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;

    taken = (bs == 2'b11) || (bs == 2'b10) || (bs == 2'b01 && ps != z);
    tgt   = (bs == 2'b10) ? raa : bra;
    if (rst) begin
      m_pc = RESET_PC;
      m_out.pc = '0; m_out.npc = '0; m_out.ir = '0; m_out.valid = 1'b0; m_out.cnt = 0;
    end else if (taken) begin
      m_pc = tgt;
      m_out.ir = '0;
      m_out.valid = 1'b0;
      if (m_out.cnt < CNT_MAX) m_out.cnt = m_out.cnt + 1;
    end else if (!stl) begin
      m_out.pc = m_pc;
      m_out.npc = m_pc + 32'd1;
      m_out.ir = m_mem[int'(m_pc % DEPTH)];
      m_out.valid = 1'b1;
      m_pc = m_pc + 32'd1;
    end
    // Memory updates after the fetch read: old word seen on a same-cycle hit
    if (we) m_mem[wa] = wd;
    exp_q.push_back(m_out);
  endtask

  task automatic seq();
    cyc(0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 0, 8'h0, 32'h0);
  endtask

  // Monitor: compare every registered output against the oldest expectation
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        compared++;
        if (IF_DOF_PC !== mon_e.pc || IF_DOF_NPC !== mon_e.npc || IF_DOF_IR !== mon_e.ir ||
            IF_DOF_VALID !== mon_e.valid || redirect_cnt !== 3'(mon_e.cnt)) begin
          mismatched++;
          $display("FAIL ifdof t=%0t got pc=%h npc=%h ir=%h v=%b cnt=%0d want pc=%h npc=%h ir=%h v=%b cnt=%0d",
                   $time, IF_DOF_PC, IF_DOF_NPC, IF_DOF_IR, IF_DOF_VALID, redirect_cnt,
                   mon_e.pc, mon_e.npc, mon_e.ir, mon_e.valid, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  logic [31:0] saved_pc;
  logic [1:0]  r_bs;
  logic [31:0] r_bra;
  logic [31:0] r_raa;
  logic [7:0]  r_wa;
  int          r;

  initial begin
    // Load the whole memory while reset is held; reset outputs checked each cycle
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 2'b00, 0, 0, 32'h0, 32'h0, 1, 8'(i), (i < 4) ? (32'hA0 + 32'(i)) : $urandom);
    end

    // Release: fetch 0x1FE, 0x1FF, then wrap of the index into 0x200..
    for (int i = 0; i < 6; i++) seq();

    // Conditional taken (PS=0, Z=1) to 0xAA, then sequential
    cyc(0, 0, 2'b01, 0, 1, 32'hAA, 32'h0, 0, 8'h0, 32'h0);
    for (int i = 0; i < 3; i++) seq();
    // Conditional not taken (PS=0, Z=0)
    cyc(0, 0, 2'b01, 0, 0, 32'h55, 32'h0, 0, 8'h0, 32'h0);
    for (int i = 0; i < 2; i++) seq();
    // Conditional taken with inverted polarity (PS=1, Z=0) to index 0
    cyc(0, 0, 2'b01, 1, 0, 32'h0, 32'h0, 0, 8'h0, 32'h0);
    for (int i = 0; i < 5; i++) seq();
    // Jump-register to 0x1FF with a decoy BrA
    cyc(0, 0, 2'b10, 0, 0, 32'h77, 32'h1FF, 0, 8'h0, 32'h0);
    for (int i = 0; i < 3; i++) seq();
    // Stall three cycles, then stall with a simultaneous jump to 0x20
    for (int i = 0; i < 3; i++) cyc(0, 1, 2'b00, 0, 0, 32'h0, 32'h0, 0, 8'h0, 32'h0);
    cyc(0, 1, 2'b11, 0, 0, 32'h20, 32'h99, 0, 8'h0, 32'h0);
    for (int i = 0; i < 2; i++) seq();
    // Overwrite the word being fetched this very cycle, then revisit it
    saved_pc = m_pc;
    cyc(0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 1, saved_pc[7:0], 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) seq();
    cyc(0, 0, 2'b11, 0, 0, saved_pc, 32'h0, 0, 8'h0, 32'h0);
    for (int i = 0; i < 2; i++) seq();
    // Back-to-back jumps drive the counter into saturation
    for (int i = 0; i < 6; i++) cyc(0, 0, 2'b11, 0, 0, 32'h40 + 32'(i), 32'h0, 0, 8'h0, 32'h0);
    for (int i = 0; i < 2; i++) seq();
    // Reset mid-stream beats both stall and redirect
    cyc(1, 1, 2'b11, 0, 0, 32'h80, 32'h0, 0, 8'h0, 32'h0);
    for (int i = 0; i < 4; i++) seq();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 9));
      r_bs  = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      r_bra = $urandom_range(0, 1) ? 32'($urandom_range(0, 600)) : $urandom;
      r_raa = $urandom_range(0, 1) ? 32'($urandom_range(0, 600)) : $urandom;
      r_wa  = $urandom_range(0, 1) ? m_pc[7:0] : 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0), r_bs,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_bra, r_raa,
          ($urandom_range(0, 2) == 0), r_wa, $urandom);
    end

    // Let the monitor drain the final expectation
    @(posedge clk);
    #4;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
